// File: rtl/reg_file_arbiter_if.sv
// Bus bundle between the two register-file masters, the arbiter and the register-file port.
// The slave modport is the arbiter's view; master is the environment's (masters + register file).
interface reg_file_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  m0_req;
  logic                  m0_wr;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_wr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_err;

  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  rf_rd_valid;

  logic                  busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    input  rf_rd_data, rf_rd_valid,
    output busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    output rf_rd_data, rf_rd_valid,
    input  busy
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// Two-master arbiter for the single-port register file, with read-valid timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed M0 priority.
module reg_file_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              RST,
  reg_file_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

  // Last WAIT_RD cycle before the timeout response is the one where the count is TIMEOUT-1.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;        // 0: M0, 1: M1
  logic                  last_owner_q, last_owner_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  m0_err_q, m0_err_d;
  logic                  m1_err_q, m1_err_d;
  logic                  grant_m1;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_m1 = bus.m1_req & (~bus.m0_req | ~last_owner_q);
`else
    grant_m1 = bus.m1_req & ~bus.m0_req;
`endif
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_owner_d     = last_owner_q;
    wr_d             = wr_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    cnt_d            = cnt_q;
    m0_rdata_d       = m0_rdata_q;
    m1_rdata_d       = m1_rdata_q;
    m0_err_d         = m0_err_q;
    m1_err_d         = m1_err_q;
    bus.rf_wr_en     = 1'b0;
    bus.rf_rd_en     = 1'b0;
    bus.rf_addr      = '0;
    bus.rf_wr_data   = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          owner_d      = grant_m1;
          last_owner_d = grant_m1;
          wr_d         = grant_m1 ? bus.m1_wr    : bus.m0_wr;
          addr_d       = grant_m1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d      = grant_m1 ? bus.m1_wdata : bus.m0_wdata;
          state_d      = StIssue;
        end
      end

      StIssue: begin
        bus.rf_addr = addr_q;
        if (wr_q) begin
          bus.rf_wr_en   = 1'b1;
          bus.rf_wr_data = wdata_q;
          // A completed write reports no error alongside its ack.
          if (owner_q) m1_err_d = 1'b0;
          else         m0_err_d = 1'b0;
          state_d = StResp;
        end else begin
          bus.rf_rd_en = 1'b1;
          state_d      = StWaitRd;
        end
      end

      StWaitRd: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.rf_rd_valid) begin
          if (owner_q) begin
            m1_rdata_d = bus.rf_rd_data;
            m1_err_d   = 1'b0;
          end else begin
            m0_rdata_d = bus.rf_rd_data;
            m0_err_d   = 1'b0;
          end
          cnt_d   = 8'd0;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          if (owner_q) begin
            m1_rdata_d = '0;
            m1_err_d   = 1'b1;
          end else begin
            m0_rdata_d = '0;
            m0_err_d   = 1'b1;
          end
          cnt_d   = 8'd0;
          state_d = StResp;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 8'd0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign bus.m0_ack   = (state_q == StResp) && !owner_q;
  assign bus.m1_ack   = (state_q == StResp) &&  owner_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.busy     = (state_q != StIdle);

endmodule
